// File: rtl/sign_mag_converter_if.sv
// Handshake and result bundle for sign_mag_converter.
// The master side offers a two's-complement byte and receives the sign plus three BCD digits.
interface sign_mag_converter_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       out_valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  sign,
        input  hundreds,
        input  tens,
        input  ones,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output sign,
        output hundreds,
        output tens,
        output ones,
        output out_valid
    );
endinterface

// File: rtl/sign_mag_converter.sv
// Converts an 8-bit two's-complement value into a sign flag and three BCD digits using a
// sequential double-dabble. Optional leading-zero blanking is enabled by SIGN_MAG_BLANK_EN.
module sign_mag_converter (
    input  logic                 clk,
    input  logic                 rst_n,
    sign_mag_converter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ABS   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [7:0]  data_q,      data_d;
    logic        sign_int_q,  sign_int_d;
    logic [7:0]  bin_q,       bin_d;
    logic [11:0] bcd_q,       bcd_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic        sign_q,      sign_d;
    logic [3:0]  hundreds_q,  hundreds_d;
    logic [3:0]  tens_q,      tens_d;
    logic [3:0]  ones_q,      ones_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q,  in_ready_d;

    logic [11:0] adj_s;
    logic [19:0] shift_s;

    function automatic logic [3:0] nibble_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
        return {nibble_adjust(bcd[11:8]), nibble_adjust(bcd[7:4]), nibble_adjust(bcd[3:0])};
    endfunction

    // One double-dabble step: correct each digit, then shift the pair left by one.
    always_comb begin
        adj_s   = dd_adjust(bcd_q);
        shift_s = {adj_s, bin_q} << 1;
    end

    // Next-state and datapath decode for the conversion FSM.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sign_int_d  = sign_int_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        hundreds_d  = hundreds_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    state_d = ST_ABS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABS: begin
                // -128 negates to 8'h80, which reads correctly as unsigned 128.
                sign_int_d = data_q[7];
                if (data_q[7]) begin
                    bin_d = 8'd0 - data_q;
                end else begin
                    bin_d = data_q;
                end
                bcd_d   = 12'd0;
                cnt_d   = 3'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = shift_s[19:8];
                bin_d = shift_s[7:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                sign_d      = sign_int_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
`ifdef SIGN_MAG_BLANK_EN
                if (bcd_q[11:8] == 4'd0) begin
                    hundreds_d = 4'hF;
                end else begin
                    hundreds_d = bcd_q[11:8];
                end
                if ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) begin
                    tens_d = 4'hF;
                end else begin
                    tens_d = bcd_q[7:4];
                end
`else
                hundreds_d = bcd_q[11:8];
                tens_d     = bcd_q[7:4];
`endif
                ones_d = bcd_q[3:0];
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State, scratch and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= 8'd0;
            sign_int_q  <= 1'b0;
            bin_q       <= 8'd0;
            bcd_q       <= 12'd0;
            cnt_q       <= 3'd0;
            sign_q      <= 1'b0;
            hundreds_q  <= 4'd0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sign_int_q  <= sign_int_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            hundreds_q  <= hundreds_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sign      = sign_q;
    assign bus.hundreds  = hundreds_q;
    assign bus.tens      = tens_q;
    assign bus.ones      = ones_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_mag_converter.sv
// Self-checking bench for sign_mag_converter: directed corner cases plus random values
// compared against an arithmetic reference model.
module tb_sign_mag_converter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sign_mag_converter_if ifc();

    sign_mag_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of |value| computed with integer arithmetic.
    function automatic void model(input logic [7:0] v, output logic s,
                                  output logic [3:0] h, output logic [3:0] t, output logic [3:0] o);
        int x;
        x = int'($signed(v));
        s = (x < 0);
        if (x < 0) x = -x;
        h = 4'(x / 100);
        t = 4'((x / 10) % 10);
        o = 4'(x % 10);
`ifdef SIGN_MAG_BLANK_EN
        if (h == 4'd0) begin
            if (t == 4'd0) t = 4'hF;
            h = 4'hF;
        end
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Capture v, then wait (bounded) for out_valid; reports latency and busy-time ready violations.
    task automatic run_conv(input logic [7:0] v, output int lat, output int busy_err);
        lat = -1;
        busy_err = 0;
        for (int k = 0; k < 30 && !ifc.in_ready; k++) tick();
        ifc.in_valid = 1'b1;
        ifc.in_data  = v;
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'($urandom);
        if (ifc.in_ready !== 1'b0) busy_err++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ifc.out_valid === 1'b1) begin
                lat = i;
                break;
            end
            if (ifc.in_ready !== 1'b0) busy_err++;
        end
    endtask

    task automatic check_conv(input string name, input logic [7:0] v);
        int lat, busy_err;
        logic s;
        logic [3:0] h, t, o;
        model(v, s, h, t, o);
        run_conv(v, lat, busy_err);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL %s latency: got %0d want 10 (in=%h)", name, lat, v);
        end
        checks++;
        if (busy_err !== 0) begin
            errors++;
            $display("FAIL %s in_ready_busy: %0d cycles high while converting (in=%h)", name, busy_err, v);
        end
        checks++;
        if ({ifc.sign, ifc.hundreds, ifc.tens, ifc.ones} !== {s, h, t, o}) begin
            errors++;
            $display("FAIL %s result: got %b/%h/%h/%h want %b/%h/%h/%h (in=%h)", name,
                     ifc.sign, ifc.hundreds, ifc.tens, ifc.ones, s, h, t, o, v);
        end
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 ||
            {ifc.sign, ifc.hundreds, ifc.tens, ifc.ones} !== {s, h, t, o}) begin
            errors++;
            $display("FAIL %s hold: out_valid=%b in_ready=%b digits=%h/%h/%h want 0/1 and held",
                     name, ifc.out_valid, ifc.in_ready, ifc.hundreds, ifc.tens, ifc.ones);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        tick();
        tick();
        checks++;
        if ({ifc.out_valid, ifc.sign, ifc.hundreds, ifc.tens, ifc.ones} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b s=%b %h/%h/%h want all zero",
                     ifc.out_valid, ifc.sign, ifc.hundreds, ifc.tens, ifc.ones);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ifc.in_ready);
        end
    endtask

    task automatic test_directed;
        check_conv("pos5", 8'h05);
        check_conv("neg128", 8'h80);
        check_conv("zero", 8'h00);
        check_conv("neg10", 8'hF6);
        check_conv("pos127", 8'h7F);
        check_conv("neg1", 8'hFF);
        check_conv("pos100", 8'h64);
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++) check_conv("random", 8'($urandom_range(255, 0)));
    endtask

    task automatic test_back_to_back;
        int p1, p2, rdy_err;
        logic [12:0] r1, r2;
        logic s;
        logic [3:0] h, t, o;
        p1 = -1; p2 = -1; rdy_err = 0; r1 = '0; r2 = '0;
        for (int k = 0; k < 30 && !ifc.in_ready; k++) tick();
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h81;
        tick();
        ifc.in_data  = 8'h7F;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (ifc.out_valid === 1'b1) begin
                if (p1 < 0) begin
                    p1 = i; r1 = {ifc.sign, ifc.hundreds, ifc.tens, ifc.ones};
                end else if (p2 < 0) begin
                    p2 = i; r2 = {ifc.sign, ifc.hundreds, ifc.tens, ifc.ones};
                end
            end
            if (ifc.in_ready !== ((i == 10) || (i >= 21))) rdy_err++;
            if (i == 11) ifc.in_valid = 1'b0;
        end
        checks++;
        if (p1 !== 10 || p2 !== 21) begin
            errors++;
            $display("FAIL b2b_timing: pulses at %0d,%0d want 10,21", p1, p2);
        end
        checks++;
        if (rdy_err !== 0) begin
            errors++;
            $display("FAIL b2b_ready: %0d cycles with wrong in_ready want 0", rdy_err);
        end
        model(8'h81, s, h, t, o);
        checks++;
        if (r1 !== {s, h, t, o}) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", r1, {s, h, t, o});
        end
        model(8'h7F, s, h, t, o);
        checks++;
        if (r2 !== {s, h, t, o}) begin
            errors++;
            $display("FAIL b2b_second: got %h want %h", r2, {s, h, t, o});
        end
    endtask

    task automatic test_ignore_busy;
        int pulses, lat;
        logic [12:0] r;
        logic [7:0] v;
        logic s;
        logic [3:0] h, t, o;
        pulses = 0; lat = -1; r = '0;
        v = 8'($urandom_range(255, 2));
        model(v, s, h, t, o);
        for (int k = 0; k < 30 && !ifc.in_ready; k++) tick();
        ifc.in_valid = 1'b1;
        ifc.in_data  = v;
        tick();
        ifc.in_valid = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (ifc.out_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = i; r = {ifc.sign, ifc.hundreds, ifc.tens, ifc.ones};
                end
            end
            if (i == 3) begin
                ifc.in_valid = 1'b1; ifc.in_data = 8'h01;
            end else if (i == 4) begin
                ifc.in_valid = 1'b0;
            end
        end
        checks++;
        if (pulses !== 1 || lat !== 10) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d pulses first at %0d want 1 at 10", pulses, lat);
        end
        checks++;
        if (r !== {s, h, t, o}) begin
            errors++;
            $display("FAIL ignore_value: got %h want %h (in=%h)", r, {s, h, t, o}, v);
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        check_conv("pre_abort", 8'h80);
        pulses = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h9C;
        tick();
        ifc.in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (ifc.out_valid === 1'b1) pulses++;
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ifc.out_valid, ifc.sign, ifc.hundreds, ifc.tens, ifc.ones} !== 14'd0) begin
            errors++;
            $display("FAIL abort_outputs: got ov=%b s=%b %h/%h/%h want all zero",
                     ifc.out_valid, ifc.sign, ifc.hundreds, ifc.tens, ifc.ones);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b want 1", ifc.in_ready);
        end
        for (int i = 0; i < 15; i++) begin
            if (ifc.out_valid === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0 || {ifc.sign, ifc.hundreds, ifc.tens, ifc.ones} !== 13'd0) begin
            errors++;
            $display("FAIL abort_no_pulse: got %0d pulses, outputs %h want 0 and 0",
                     pulses, {ifc.sign, ifc.hundreds, ifc.tens, ifc.ones});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_mag_converter.md
SIGN_MAG_CONVERTER -- requirements
Module: sign_mag_converter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic samples on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: the upstream offers in_data this cycle.
REQ-004 The block SHALL have the port in_data, input, 8 bits: a two's-complement value in the range -128..127.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: high only in IDLE.
REQ-006 The block SHALL have the port sign, output, 1 bit: 1 when the last converted value was negative; it feeds the sign-segment display stage.
REQ-007 The block SHALL have the port hundreds, output, 4 bits: BCD hundreds digit of the magnitude.
REQ-008 The block SHALL have the port tens, output, 4 bits: BCD tens digit.
REQ-009 The block SHALL have the port ones, output, 4 bits: BCD ones digit.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: a one-cycle pulse when sign and the digits update.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, ABS, SHIFT and DONE.
REQ-012 In IDLE, in_ready SHALL be 1, and in_valid=1 SHALL capture in_data and move the FSM to ABS.
REQ-013 In ABS, lasting 1 cycle, the block SHALL set the internal sign to in_data[7] and form the 8-bit unsigned magnitude: negate if negative, else pass through; -128 SHALL give 128.
REQ-014 In SHIFT, lasting exactly 8 cycles, the block SHALL run double-dabble on a 12-bit BCD scratch register, adding 3 to any nibble >=5 before each left shift, MSB first, with a 3-bit counter running 0..7.
REQ-015 In DONE, lasting 1 cycle, the block SHALL load sign, hundreds, tens and ones from the scratch registers, pulse out_valid=1, and return to IDLE.
REQ-016 Latency SHALL be fixed: with capture at edge N, out_valid SHALL be high in the cycle after edge N+10; the next capture is possible at edge N+11.
REQ-017 in_valid SHALL be ignored while in_ready=0; no queueing and no error flag.
REQ-018 sign, hundreds, tens and ones SHALL hold their last values between DONE pulses.
REQ-019 Zero input SHALL produce sign=0 and digits 0/0/0; the block never outputs negative zero.
REQ-020 hundreds SHALL only take the values 0 or 1 when blanking is off.
REQ-021 out_valid and in_ready SHALL be registered outputs.

Reset
REQ-022 When rst_n=0 at a clock edge, the FSM SHALL enter IDLE and the counter and scratch registers SHALL clear.
REQ-023 When rst_n=0 at a clock edge, sign=0, hundreds=0, tens=0, ones=0 and out_valid=0.
REQ-024 After reset, in_ready SHALL be 1 from the first cycle after rst_n rises.
REQ-025 A reset during ABS, SHIFT or DONE SHALL abort the conversion, produce no out_valid pulse, and apply the REQ-023 output values.

Configuration
REQ-026 The macro SIGN_MAG_BLANK_EN SHALL enable leading-zero blanking: in DONE, hundreds=4'hF when it is 0, and tens=4'hF when both hundreds and tens are 0; ones is never blanked.
REQ-027 Without SIGN_MAG_BLANK_EN, all three digits SHALL always be plain BCD.
REQ-028 Reset values SHALL be unaffected by SIGN_MAG_BLANK_EN.

Verification
REQ-029 After reset, in_data=8'h05 with in_valid=1 for 1 cycle -> out_valid 10 cycles later; sign=0, digits 0/0/5 (blank on: F/F/5).
REQ-030 in_data=8'h80 (-128) -> sign=1, digits 1/2/8.
REQ-031 in_data=8'h81 (-127), then in_data=8'h7F (127) with in_valid held high continuously -> two out_valid pulses 11 cycles apart: sign=1, 1/2/7, then sign=0, 1/2/7; in_ready low during both conversions.
REQ-032 in_data=8'h00 -> sign=0, digits 0/0/0 (blank on: F/F/0); in_data=8'hF6 (-10) -> sign=1, digits 0/1/0 (blank on: F/1/0).
REQ-033 Capture 8'h9C (-100), assert rst_n=0 at SHIFT cycle 4 -> no out_valid pulse, outputs 0/0/0/0, in_ready=1 the cycle after rst_n rises.
REQ-034 Pulse in_valid with 8'h01 three cycles after a capture -> ignored; only the first value appears at out_valid.
